seven_seg_scan: RTL
===================

# seven_seg_scan

Multiplexed 4-digit seven-segment display driver that consumes the four BCD digits and active-digit index produced by the code-entry counter. It snapshots the digits once per scan frame, time-multiplexes them onto a common-anode display with inter-digit blanking, and marks the digit being edited with a blinking digit and a lit decimal point. It sits between the code-entry logic and the display Pmod pins.

## Interface
- SCAN_DIV, 125000: clock cycles per digit slot; ≥ 4.
- BLANK_CYC, 1250: cycles at the start of each slot with all anodes off; 1 ≤ BLANK_CYC < SCAN_DIV.
- BLINK_DIV, 31250000: cycles per blink half-period; ≥ 2.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- bcd0..bcd3  in  4 each  digit values; bcd0 is the rightmost digit.
- active_digit  in  2  index of the digit being edited.
- blink_en  in  1  enables blinking of the active digit.
- an  out  4  anode enables, active-low; an[i] selects digit i.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- State:
  - slot counter cnt: 0..SCAN_DIV-1.
  - digit index d: 0..3.
  - four 4-bit shadow registers.
  - blink counter and blink phase bit ph.
- Scan:
  - When cnt==SCAN_DIV-1: cnt←0 and d←d+1, wrapping 3→0.
  - Otherwise cnt←cnt+1.
- Snapshot: on the edge where d goes 3→0 (the frame boundary), shadow[i]←bcd[i] for all four digits in the same edge. active_digit and blink_en are not snapshotted; they are sampled every cycle.
- Blink: the blink counter wraps at BLINK_DIV-1, and ph toggles on each wrap.
- Outputs are registered from the current-cycle state:
  - an: all 1 while cnt<BLANK_CYC. Also all 1 when blink_en=1, ph=1 and d==active_digit. Otherwise an[d]=0 and the other three bits are 1.
  - seg: decode of shadow[d].
    - 0–9 give the standard patterns: 0=1000000, 1=1111001, 5=0010010, 8=0000000.
    - 10–15 give a dash (0111111).
  - dp: 0 when d==active_digit, else 1. dp is gated by the same anode visibility; it is not independently visible.
- The shadow registers remove tearing: an input change mid-frame never shows partially.

## Timing
- Reset, applied asynchronously:
  - Outputs: an=1111, seg=1111111, dp=1.
  - State: cnt=0, d=0, shadows=0, blink counter=0, ph=0.
- Output latency: one cycle after the state that produces it. The first visible digit appears at the output on cycle BLANK_CYC+1 after reset release.
- Each digit is visible for SCAN_DIV−BLANK_CYC cycles per slot; a full frame is 4·SCAN_DIV cycles.
- Input-to-display latency: the change appears from the first frame boundary after it, plus one cycle. Worst case is 4·SCAN_DIV+1.
- Simultaneous events:
  - A bcd change on the frame-boundary edge itself is captured.
  - An active_digit change takes effect on the next cycle, in any slot.
- Reset mid-frame: outputs go off immediately without a clock edge. The scan restarts at digit 0 and the shadows clear to 0.

## Structure
- Shared package seg7_pkg holds:
  - the segment pattern constants (SEG_DIGIT[0:9], SEG_DASH, SEG_OFF);
  - AN_OFF;
  - the digit-count constant NUM_DIGITS=4.
- One sub-module, bcd_to_seg7: combinational, 4-bit in, 7-bit active-low out, dash for values >9. The top module instantiates it once on the muxed shadow[d].

## Test plan
Run with SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=64.
- Reset:
  - Assert rst asynchronously mid-cycle → an=1111, seg=1111111, dp=1 with no clock edge.
  - After release, an=1111 for 2 cycles, then an=1110 with seg=1000000.
- Static digits:
  - Stimulus: bcd3..0=8,5,1,0 held, active_digit=3, blink_en=0.
  - After the next frame boundary, the slots show:
    - an=1110 / seg=1000000 / dp=1
    - an=1101 / seg=1111001
    - an=1011 / seg=0010010
    - an=0111 / seg=0000000 / dp=0
  - Each visible slot lasts 6 cycles.
- Tearing:
  - Change bcd0 from 0 to 1 while d=1.
  - Digit 0 still shows 1000000 in the rest of that frame, and shows 1111001 only from the next frame.
- Invalid BCD: bcd2=4'hC → slot 2 shows seg=0111111.
- Blink:
  - Stimulus: blink_en=1, active_digit=2.
  - an[2] stays 1 through every slot-2 window while ph=1, and behaves normally while ph=0. The phase toggles every 64 cycles.
  - Digits 0, 1 and 3 are unaffected.
- Reset mid-operation: pulse rst during slot 3 with nonzero digits → the display blanks at once, the shadows read 0, and the scan resumes at digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns,
// anode-off value and digit count. All display encodings are active-low.
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] bcd_t;

  localparam int unsigned NUM_DIGITS = 4;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  localparam seg_t       SEG_DASH = 7'b0111111;
  localparam seg_t       SEG_OFF  = 7'b1111111;
  localparam logic [3:0] AN_OFF   = 4'b1111;

endpackage

// File: rtl/seven_seg_scan_if.sv
// Bundle between the code-entry logic (master) and the display driver (slave):
// digit values and edit cursor in, anode/segment/decimal-point pins out.
interface seven_seg_scan_if;

  logic [3:0]       bcd0;
  logic [3:0]       bcd1;
  logic [3:0]       bcd2;
  logic [3:0]       bcd3;
  logic [1:0]       active_digit;
  logic             blink_en;
  logic [3:0]       an;
  seg7_pkg::seg_t   seg;
  logic             dp;

  modport master (
    output bcd0, bcd1, bcd2, bcd3, active_digit, blink_en,
    input  an, seg, dp
  );

  modport slave (
    input  bcd0, bcd1, bcd2, bcd3, active_digit, blink_en,
    output an, seg, dp
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; codes above 9 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd < 4'd10) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed 4-digit common-anode display driver with per-frame digit snapshot,
// inter-digit blanking and a blinking/decimal-point marker on the edited digit.
module seven_seg_scan
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 125000,
  parameter int unsigned BLANK_CYC = 1250,
  parameter int unsigned BLINK_DIV = 31250000
) (
  input logic              clk,
  input logic              rst,
  seven_seg_scan_if.slave  bus
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    d;
  bcd_t          shadow [NUM_DIGITS];
  logic [BW-1:0] bcnt;
  logic          ph;

  logic [3:0]    an_q;
  seg_t          seg_q;
  logic          dp_q;

  bcd_t          shadow_cur;
  seg_t          seg_dec;
  logic          slot_end;
  logic          frame_end;
  logic          is_active;
  logic          visible;

  assign shadow_cur = shadow[d];
  assign slot_end   = (cnt == CNT_MAX);
  assign frame_end  = slot_end && (d == 2'd3);
  assign is_active  = (d == bus.active_digit);
  // Blanking window and the blink-off phase both hide the digit and its point.
  assign visible    = (cnt >= CNT_BLANK) && !(bus.blink_en && ph && is_active);

  bcd_to_seg7 u_dec (
    .bcd (shadow_cur),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      d     <= '0;
      bcnt  <= '0;
      ph    <= 1'b0;
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        d   <= d + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Capture on the 3->0 digit transition so a frame never mixes old and new values.
      if (frame_end) begin
        shadow[0] <= bus.bcd0;
        shadow[1] <= bus.bcd1;
        shadow[2] <= bus.bcd2;
        shadow[3] <= bus.bcd3;
      end

      if (bcnt == BLINK_MAX) begin
        bcnt <= '0;
        ph   <= ~ph;
      end else begin
        bcnt <= bcnt + 1'b1;
      end

      an_q  <= visible ? ~(4'b0001 << d) : AN_OFF;
      seg_q <= seg_dec;
      dp_q  <= !(visible && is_active);
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule
